sd_sender: RTL and testbench

Transmit-side stage of the SPI-mode SD controller. It sits directly upstream of the card's MOSI line and mirrors sd_receiver on the MISO side.
- Serialises either a 48-bit command frame (with generated CRC7) or a write data block (start token 0xFE, payload, generated CRC16).
- Shifts one bit per SPI clock-enable tick, MSB first.
- Hands back to the controller through a valid/ready handshake.

---
 rtl/sd_sender_pkg.sv | 22 ++
 rtl/sd_crc_serial.sv | 38 +++
 rtl/sd_sender.sv | 181 ++++++++++++++++++
 tb/tb_sd_sender.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/sd_sender_pkg.sv
// sd_sender_pkg: shared types and constants for the SPI-mode SD
// transmit path (sd_sender, sd_crc_serial).
package sd_sender_pkg;

    typedef enum logic [1:0] {
        Idle,
        SendingToken,
        SendingPayload,
        SendingCrc
    } sd_sender_fsm_t;

    localparam int CmdFrameSize   = 48;
    localparam int CmdPayloadSize = 40;
    localparam int DataTokenSize  = 8;
    localparam int CrcSize16      = 16;
    localparam int CntWidth       = 13;

    localparam logic [7:0]  DataStartToken = 8'hFE;
    localparam logic [6:0]  Crc7Poly       = 7'h09;
    localparam logic [15:0] Crc16Poly      = 16'h1021;

endpackage

// File: rtl/sd_crc_serial.sv
// sd_crc_serial: bit-serial CRC generator/checker, MSB first.
// crc_next_o is the value crc_o takes if bit_i is clocked in now.
module sd_crc_serial #(
    parameter int unsigned      Width = 7,
    parameter logic [Width-1:0] Poly  = {{(Width-4){1'b0}}, 4'h9}
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clear_i,
    input  logic             en_i,
    input  logic             bit_i,
    output logic [Width-1:0] crc_o,
    output logic [Width-1:0] crc_next_o
);

    logic [Width-1:0] crc_q;
    logic             fb;

    // One LFSR step: feedback is the incoming bit xor the CRC MSB.
    always_comb begin
        fb         = bit_i ^ crc_q[Width-1];
        crc_next_o = {crc_q[Width-2:0], 1'b0} ^ ({Width{fb}} & Poly);
    end

    // CRC register; clear wins over enable.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            crc_q <= '0;
        end else if (clear_i) begin
            crc_q <= '0;
        end else if (en_i) begin
            crc_q <= crc_next_o;
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/sd_sender.sv
// sd_sender: serialises SD command frames (CRC7) and write data
// blocks (token, payload, CRC16) onto MOSI, one bit per sck_tick.
module sd_sender
    import sd_sender_pkg::*;
#(
    parameter int BLOCK_BYTES = 512
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     sck_tick,
    input  logic                     data_in_valid,
    output logic                     data_in_ready,
    input  logic                     sending_cmd,
    input  logic [5:0]               cmd_index,
    input  logic [31:0]              cmd_argument,
    input  logic [8*BLOCK_BYTES-1:0] data_block,
    output logic                     mosi,
    output logic                     busy
);

    localparam int PW = 8 * BLOCK_BYTES;
    localparam int SW = PW + DataTokenSize;

    localparam logic [CntWidth-1:0] TokEnd =
        CntWidth'(DataTokenSize - 1);
    localparam logic [CntWidth-1:0] CmdPayEnd =
        CntWidth'(CmdPayloadSize - 1);
    localparam logic [CntWidth-1:0] CmdEnd =
        CntWidth'(CmdFrameSize - 1);
    localparam logic [CntWidth-1:0] DataPayEnd =
        CntWidth'(DataTokenSize + PW - 1);
    localparam logic [CntWidth-1:0] DataEnd =
        CntWidth'(DataTokenSize + PW + CrcSize16 - 1);
    localparam logic [CntWidth-1:0] CmdCrcBase =
        CntWidth'(CmdPayloadSize);
    localparam logic [CntWidth-1:0] DataCrcBase =
        CntWidth'(DataTokenSize + PW);

    sd_sender_fsm_t      state_q;
    logic                mosi_q;
    logic                busy_q;
    logic                ready_q;
    logic                cmd_q;
    logic [CntWidth-1:0] cnt_q;
    logic [SW-1:0]       shreg_q;

    logic                accept;
    logic [SW-1:0]       load_frame;
    logic [CntWidth-1:0] cnt_nx;
    logic [CntWidth-1:0] pay_end;
    logic [CntWidth-1:0] frame_end;
    logic [CntWidth-1:0] crc_base;
    logic [3:0]          crc_j;
    logic [15:0]         crc_seq;
    logic                crc_bit;
    logic                crc_first;
    logic                crc_en;

    logic [6:0]  crc7_q;
    logic [6:0]  crc7_next;
    logic [15:0] crc16_q;
    logic [15:0] crc16_next;

    // Frame selection, bit-position bookkeeping and CRC bit pick.
    always_comb begin
        accept = data_in_valid && ready_q && (state_q == Idle);
        if (sending_cmd) begin
            load_frame = {2'b01, cmd_index, cmd_argument,
                          {(SW - CmdPayloadSize){1'b0}}};
        end else begin
            load_frame = {DataStartToken, data_block};
        end
        cnt_nx    = cnt_q + 1'b1;
        pay_end   = cmd_q ? CmdPayEnd  : DataPayEnd;
        frame_end = cmd_q ? CmdEnd     : DataEnd;
        crc_base  = cmd_q ? CmdCrcBase : DataCrcBase;
        crc_j     = 4'(cnt_nx - crc_base);
        crc_seq   = cmd_q ? {crc7_q, 1'b1, 8'h00} : crc16_q;
        crc_bit   = crc_seq[~crc_j];
        crc_first = cmd_q ? crc7_next[6] : crc16_next[15];
        crc_en    = sck_tick && (state_q == SendingPayload);
    end

    sd_crc_serial #(
        .Width (7),
        .Poly  (Crc7Poly)
    ) u_crc7 (
        .clock      (clock),
        .reset_n    (reset_n),
        .clear_i    (accept),
        .en_i       (crc_en && cmd_q),
        .bit_i      (mosi_q),
        .crc_o      (crc7_q),
        .crc_next_o (crc7_next)
    );

    sd_crc_serial #(
        .Width (16),
        .Poly  (Crc16Poly)
    ) u_crc16 (
        .clock      (clock),
        .reset_n    (reset_n),
        .clear_i    (accept),
        .en_i       (crc_en && !cmd_q),
        .bit_i      (mosi_q),
        .crc_o      (crc16_q),
        .crc_next_o (crc16_next)
    );

    // Transmit FSM with registered MOSI, busy and ready.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= Idle;
            mosi_q  <= 1'b1;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            cmd_q   <= 1'b0;
            cnt_q   <= '0;
            shreg_q <= '0;
        end else begin
            unique case (state_q)
                Idle: begin
                    if (accept) begin
                        cmd_q   <= sending_cmd;
                        mosi_q  <= load_frame[SW-1];
                        shreg_q <= {load_frame[SW-2:0], 1'b0};
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        ready_q <= 1'b0;
                        state_q <= sending_cmd ? SendingPayload
                                               : SendingToken;
                    end
                end
                SendingToken: begin
                    if (sck_tick) begin
                        mosi_q  <= shreg_q[SW-1];
                        shreg_q <= {shreg_q[SW-2:0], 1'b0};
                        cnt_q   <= cnt_nx;
                        if (cnt_q == TokEnd) begin
                            state_q <= SendingPayload;
                        end
                    end
                end
                SendingPayload: begin
                    if (sck_tick) begin
                        cnt_q <= cnt_nx;
                        if (cnt_q == pay_end) begin
                            mosi_q  <= crc_first;
                            state_q <= SendingCrc;
                        end else begin
                            mosi_q  <= shreg_q[SW-1];
                            shreg_q <= {shreg_q[SW-2:0], 1'b0};
                        end
                    end
                end
                SendingCrc: begin
                    if (sck_tick) begin
                        if (cnt_q == frame_end) begin
                            mosi_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            ready_q <= 1'b1;
                            cnt_q   <= '0;
                            state_q <= Idle;
                        end else begin
                            mosi_q <= crc_bit;
                            cnt_q  <= cnt_nx;
                        end
                    end
                end
                default: begin
                    state_q <= Idle;
                end
            endcase
        end
    end

    assign data_in_ready = ready_q;
    assign busy          = busy_q;
    assign mosi          = mosi_q;

endmodule

// File: tb/tb_sd_sender.sv
// tb_sd_sender: directed bench for sd_sender, capturing MOSI
// bit by bit and comparing against hand-computed frames.
module tb_sd_sender;

    localparam int BB = 512;
    localparam int DN = 8 + 8 * BB + 16;

    logic          clock;
    logic          reset_n;
    logic          sck_tick;
    logic          data_in_valid;
    logic          data_in_ready;
    logic          sending_cmd;
    logic [5:0]    cmd_index;
    logic [31:0]   cmd_argument;
    logic [8*BB-1:0] data_block;
    logic          mosi;
    logic          busy;

    int            n_assert;
    int            n_fail;
    logic [DN-1:0] cap;
    int            err;
    int            cnt;

    sd_sender #(
        .BLOCK_BYTES (BB)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .sck_tick      (sck_tick),
        .data_in_valid (data_in_valid),
        .data_in_ready (data_in_ready),
        .sending_cmd   (sending_cmd),
        .cmd_index     (cmd_index),
        .cmd_argument  (cmd_argument),
        .data_block    (data_block),
        .mosi          (mosi),
        .busy          (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_chk(input string tag);
        chk({tag, "_mosi"},  64'(mosi), 64'd1);
        chk({tag, "_busy"},  64'(busy), 64'd0);
        chk({tag, "_ready"}, 64'(data_in_ready), 64'd1);
    endtask

    task automatic tick(input int gap);
        repeat (gap - 1) @(negedge clock);
        sck_tick = 1'b1;
        @(negedge clock);
        sck_tick = 1'b0;
    endtask

    task automatic start(input bit c, input logic [5:0] idx,
                         input logic [31:0] arg, input logic [7:0] fill,
                         input int nbits);
        sending_cmd   = c;
        cmd_index     = idx;
        cmd_argument  = arg;
        data_block    = {BB{fill}};
        data_in_valid = 1'b1;
        @(negedge clock);
        data_in_valid = 1'b0;
        sending_cmd   = ~c;
        cmd_index     = ~idx;
        cmd_argument  = ~arg;
        data_block    = ~data_block;
        chk("acc_busy",  64'(busy), 64'd1);
        chk("acc_ready", 64'(data_in_ready), 64'd0);
        cap = '0;
        cap[nbits-1] = mosi;
    endtask

    task automatic recv(input int nbits, input int from, input int upto,
                        input int gap, input int stall_at,
                        output int bad);
        logic m;
        bad = 0;
        for (int k = from; k <= upto; k++) begin
            tick(gap);
            if (k < nbits) begin
                cap[nbits-1-k] = mosi;
                if (!busy || data_in_ready) bad++;
            end
            if (k == stall_at) begin
                m = mosi;
                repeat (100) begin
                    @(negedge clock);
                    if (mosi !== m || !busy) bad++;
                end
            end
        end
    endtask

    initial begin
        n_assert      = 0;
        n_fail        = 0;
        reset_n       = 1'b0;
        sck_tick      = 1'b0;
        data_in_valid = 1'b0;
        sending_cmd   = 1'b0;
        cmd_index     = '0;
        cmd_argument  = '0;
        data_block    = '0;
        repeat (3) @(negedge clock);
        idle_chk("reset");
        reset_n = 1'b1;
        @(negedge clock);
        repeat (3) tick(2);
        idle_chk("idle_tick");

        // CMD0, tick every 4 cycles
        start(1'b1, 6'd0, 32'h0, 8'h00, 48);
        chk("cmd0_bit0", 64'(cap[47]), 64'd0);
        recv(48, 1, 48, 4, 0, err);
        chk("cmd0_frame", 64'(cap[47:0]), 64'h40_0000_0000_95);
        chk("cmd0_hold", 64'(err), 64'd0);
        idle_chk("cmd0_end");

        // CMD8 with stall and ignored valid mid-frame
        start(1'b1, 6'd8, 32'h0000_01AA, 8'h00, 48);
        recv(48, 1, 20, 3, 20, err);
        chk("cmd8_stall", 64'(err), 64'd0);
        sending_cmd   = 1'b1;
        cmd_index     = 6'd0;
        cmd_argument  = 32'h0;
        data_in_valid = 1'b1;
        repeat (5) @(negedge clock);
        data_in_valid = 1'b0;
        chk("cmd8_ign_busy", 64'(busy), 64'd1);
        recv(48, 21, 48, 3, 0, err);
        chk("cmd8_frame", 64'(cap[47:0]), 64'h48_0000_01AA_87);
        chk("cmd8_hold", 64'(err), 64'd0);
        idle_chk("cmd8_end");

        // Data block of all 0xFF
        start(1'b0, 6'd0, 32'h0, 8'hFF, DN);
        chk("ff_bit0", 64'(cap[DN-1]), 64'd1);
        recv(DN, 1, DN, 2, 0, err);
        chk("ff_token", 64'(cap[DN-1 -: 8]), 64'hFE);
        cnt = 0;
        for (int i = 16; i < DN - 8; i++) if (cap[i] !== 1'b1) cnt++;
        chk("ff_payload", 64'(cnt), 64'd0);
        chk("ff_crc", 64'(cap[15:0]), 64'h7FA1);
        chk("ff_hold", 64'(err), 64'd0);
        idle_chk("ff_end");

        // Data block of all 0x00, then back-to-back CMD17
        start(1'b0, 6'd0, 32'h0, 8'h00, DN);
        recv(DN, 1, DN - 1, 2, 0, err);
        chk("zz_token", 64'(cap[DN-1 -: 8]), 64'hFE);
        cnt = 0;
        for (int i = 16; i < DN - 8; i++) if (cap[i] !== 1'b0) cnt++;
        chk("zz_payload", 64'(cnt), 64'd0);
        chk("zz_crc", 64'(cap[15:0]), 64'h0000);
        chk("zz_hold", 64'(err), 64'd0);
        sending_cmd   = 1'b1;
        cmd_index     = 6'd17;
        cmd_argument  = 32'h0;
        data_in_valid = 1'b1;
        tick(2);
        idle_chk("b2b_gap");
        @(negedge clock);
        data_in_valid = 1'b0;
        chk("b2b_busy",  64'(busy), 64'd1);
        chk("b2b_ready", 64'(data_in_ready), 64'd0);
        cap = '0;
        cap[47] = mosi;
        recv(48, 1, 48, 2, 0, err);
        chk("cmd17_frame", 64'(cap[47:0]), 64'h51_0000_0000_55);
        chk("cmd17_hold", 64'(err), 64'd0);
        idle_chk("cmd17_end");

        // Reset mid-command, then clean CMD0
        start(1'b1, 6'd8, 32'h0000_01AA, 8'h00, 48);
        recv(48, 1, 20, 2, 0, err);
        #1 reset_n = 1'b0;
        #1 idle_chk("async_rst");
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        idle_chk("post_rst");
        start(1'b1, 6'd0, 32'h0, 8'h00, 48);
        recv(48, 1, 48, 2, 0, err);
        chk("cmd0b_frame", 64'(cap[47:0]), 64'h40_0000_0000_95);
        chk("cmd0b_hold", 64'(err), 64'd0);
        idle_chk("cmd0b_end");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
